// File: rtl/bcd_timer_updown.sv
// -----------------------------------------------------------------------------
// bcd_timer_updown
//   Packed-BCD up/down timer with prescaled tick, preset load, level pause,
//   terminal detection and a done flag. Drives the 7-segment display driver
//   (digit_time) and takes start/pause/load from the oven control FSM.
//
//   Build option: define TIMER_WRAP_EN to make the count wrap at the terminal
//   value (done becomes a one-cycle pulse). When undefined, reaching the
//   terminal value parks the timer in DONE with done held high.
// -----------------------------------------------------------------------------
module bcd_timer_updown #(
    parameter int DIGITS   = 2,   // number of BCD digits, 1..4
    parameter int TICK_DIV = 1,   // clock cycles per count step, >= 1
    parameter int CNT_W    = 8    // width of the elapsed-tick counter
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  mode,
    output logic [4*DIGITS-1:0]   digit_time,
    output logic [CNT_W-1:0]      current_time,
    output logic                  running,
    output logic                  done
);

    // Prescaler only needs to reach TICK_DIV-1; keep at least one bit so the
    // TICK_DIV=1 build still has a legal (constant-zero) register.
    localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};
    localparam logic [CNT_W-1:0]    CNT_SAT   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSED,
        ST_DONE
    } state_t;

    // -------------------------------------------------------------------------
    // BCD helpers
    // -------------------------------------------------------------------------

    // Increment with digit carry; a 9 rolls to 0 and carries into the next
    // digit. The top digit's carry-out is dropped, so all nines becomes zero.
    function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] res;
        logic                carry;
        logic [3:0]          d;
        res   = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (carry) begin
                if (d >= 4'd9) begin
                    res[4*i +: 4] = 4'd0;
                    carry         = 1'b1;
                end else begin
                    res[4*i +: 4] = d + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        return res;
    endfunction

    // Decrement with digit borrow; a 0 rolls to 9 and borrows from the next
    // digit. All zeros becomes all nines.
    function automatic logic [4*DIGITS-1:0] bcd_dec(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] res;
        logic                borrow;
        logic [3:0]          d;
        res    = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (borrow) begin
                if (d == 4'd0) begin
                    res[4*i +: 4] = 4'd9;
                    borrow        = 1'b1;
                end else begin
                    res[4*i +: 4] = d - 4'd1;
                    borrow        = 1'b0;
                end
            end
        end
        return res;
    endfunction

    // Force every nibble into 0..9 so an out-of-range preset can never leak
    // an invalid BCD digit to the display.
    function automatic logic [4*DIGITS-1:0] bcd_clamp(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] res;
        for (int i = 0; i < DIGITS; i++) begin
            res[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
        end
        return res;
    endfunction

    // Terminal value for a direction: all nines counting up, all zeros down.
    function automatic logic is_terminal(input logic dir_down,
                                         input logic [4*DIGITS-1:0] v);
        return dir_down ? (v == '0) : (v == ALL_NINES);
    endfunction

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t               r_state;
    logic [4*DIGITS-1:0]  r_digits;
    logic [CNT_W-1:0]     r_count;
    logic [PW-1:0]        r_presc;
    logic                 r_dir_down;
    logic                 r_done;

    state_t               w_state_nx;
    logic [4*DIGITS-1:0]  w_digits_nx;
    logic [CNT_W-1:0]     w_count_nx;
    logic [PW-1:0]        w_presc_nx;
    logic                 w_dir_down_nx;
    logic                 w_done_nx;
    logic [4*DIGITS-1:0]  w_stepped;

    // One step of the count in the latched direction.
    assign w_stepped = r_dir_down ? bcd_dec(r_digits) : bcd_inc(r_digits);

    // Next-state and datapath decode; priority is load > start > pause.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        w_state_nx    = r_state;
        w_digits_nx   = r_digits;
        w_count_nx    = r_count;
        w_presc_nx    = r_presc;
        w_dir_down_nx = r_dir_down;
`ifdef TIMER_WRAP_EN
        w_done_nx     = 1'b0;     // done is a single-cycle pulse in wrap mode
`else
        w_done_nx     = r_done;   // done is sticky until load/rst
`endif

        if (load) begin
            w_state_nx  = ST_IDLE;
            w_digits_nx = bcd_clamp(load_val);
            w_count_nx  = '0;
            w_presc_nx  = '0;
            w_done_nx   = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_dir_down_nx = mode;
                        w_presc_nx    = '0;
                        w_count_nx    = '0;
`ifdef TIMER_WRAP_EN
                        w_state_nx    = ST_RUN;
`else
                        // Already at the terminal value: finish without stepping.
                        if (is_terminal(mode, r_digits)) begin
                            w_state_nx = ST_DONE;
                            w_done_nx  = 1'b1;
                        end else begin
                            w_state_nx = ST_RUN;
                        end
`endif
                    end
                end

                ST_RUN: begin
                    if (pause) begin
                        // Freeze value and prescaler phase; no tick this cycle.
                        w_state_nx = ST_PAUSED;
                    end else if (r_presc == PRESC_MAX) begin
                        w_presc_nx  = '0;
                        w_digits_nx = w_stepped;
                        if (r_count != CNT_SAT) begin
                            w_count_nx = r_count + 1'b1;
                        end
`ifdef TIMER_WRAP_EN
                        // Stepping off the terminal value is the wrap event.
                        if (is_terminal(r_dir_down, r_digits)) begin
                            w_done_nx = 1'b1;
                        end
`else
                        if (is_terminal(r_dir_down, w_stepped)) begin
                            w_state_nx = ST_DONE;
                            w_done_nx  = 1'b1;
                        end
`endif
                    end else begin
                        w_presc_nx = r_presc + 1'b1;
                    end
                end

                ST_PAUSED: begin
                    // Resume with the held prescaler phase once pause drops.
                    if (!pause) begin
                        w_state_nx = ST_RUN;
                    end
                end

                ST_DONE: begin
                    // Holds until load or rst; start is ignored here.
                end

                default: begin
                    w_state_nx = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs, independent of statement order.
        if (rst) begin
            r_state    <= ST_IDLE;
            r_digits   <= '0;
            r_count    <= '0;
            r_presc    <= '0;
            r_dir_down <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_digits   <= w_digits_nx;
            r_count    <= w_count_nx;
            r_presc    <= w_presc_nx;
            r_dir_down <= w_dir_down_nx;
            r_done     <= w_done_nx;
        end
    end

    assign digit_time   = r_digits;
    assign current_time = r_count;
    assign running      = (r_state == ST_RUN);
    assign done         = r_done;

endmodule

// File: doc/bcd_timer_updown.md
Name: bcd_timer_updown

Overview:
- Parametrised successor to the oven's fixed 2-digit count-up timer.
- Counts a DIGITS-wide packed-BCD display value up or down at a prescaled tick rate.
- Supports preset load, start, level pause, terminal detection and a done flag.
- Sits between the oven control FSM (start/pause/load) and the 7-segment display driver (digit_time).

Parameters:
- DIGITS, 2, number of BCD digits (1..4); digit 0 is least significant, at bits [3:0].
- TICK_DIV, 1, clock cycles per count step (>=1); 1 means step every cycle.
- CNT_W, 8, width of the elapsed-tick counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, synchronous and active-high; clears all state.
- load  in  1  load preset; aborts any run.
- load_val  in  4*DIGITS  packed BCD preset value.
- start  in  1  start counting from IDLE.
- pause  in  1  level; freezes counting while high.
- mode  in  1  0 = count up, 1 = count down; sampled at start.
- digit_time  out  4*DIGITS  packed BCD current value.
- current_time  out  CNT_W  ticks elapsed since last start.
- running  out  1  high in RUN state only.
- done  out  1  terminal indicator (see Optional Feature).

Behaviour:
- Reset: state=IDLE; digit_time=0; current_time=0; running=0; done=0; prescaler=0; latched direction=up.
- Priority per cycle: rst > load > start > pause.
- States: IDLE, RUN, PAUSED, DONE.
- load, any state: state=IDLE; digit_time=load_val with each nibble >9 clamped to 9; current_time=0; prescaler=0; done=0.
- IDLE, start=1:
  - latch mode; prescaler=0; current_time=0.
  - If down and value all zeros, or up and value all nines (non-wrap build): go to DONE next cycle, done=1, no step.
  - Otherwise go to RUN.
- RUN:
  - prescaler increments each cycle.
  - When prescaler==TICK_DIV-1: prescaler=0 and one step occurs (tick). A tick's effect is visible on outputs the following cycle.
  - Step up: BCD increment with digit carry (x9 -> next digit +1, this digit 0).
  - Step down: BCD decrement with borrow (x0 -> 9, borrow from next digit).
  - current_time increments on each tick and saturates at 2^CNT_W-1 (never wraps).
- RUN with pause=1: state=PAUSED. No tick that cycle; prescaler and value hold.
- PAUSED: everything holds. When pause=0, return to RUN and resume from the held prescaler value.
- start while RUN or PAUSED: ignored.
- DONE: value holds; start ignored; only load or rst leaves DONE.
- Terminal value: all nines (up) or all zeros (down).
- No invalid-BCD nibble is ever produced.

Optional Feature:
- Macro: TIMER_WRAP_EN.
- Undefined (default):
  - A step that lands on the terminal value moves to DONE.
  - done=1 and is held until load/rst; running=0.
  - The value stays at the terminal value.
- Defined:
  - A step from the terminal value wraps (up: all nines -> all zeros; down: all zeros -> all nines).
  - done pulses high for exactly the one cycle after the wrap; state stays RUN.
  - DONE is never entered, and start from IDLE at a terminal value runs normally.

Test Plan (DIGITS=2, CNT_W=8):
- TICK_DIV=1, load 0x07, up, start:
  - digit_time goes 07, 08, 09, 10, 11 on consecutive cycles; current_time 1..4 matches.
- TICK_DIV=1, load 0x03, down, start, non-wrap:
  - digit_time 02, 01, 00; done=1 and running=0 after 00.
  - done and value hold for 10 further cycles while start pulses.
- TICK_DIV=4, up from 00:
  - one step every 4 cycles.
  - pause high for 6 cycles mid-interval: value and prescaler frozen, running=0; resumes exact remaining phase.
- Load 0xA5:
  - digit_time=95 (clamped).
  - load asserted during RUN at value 42: IDLE, digit_time=load_val, current_time=0 next cycle.
- TIMER_WRAP_EN defined, TICK_DIV=1:
  - up from 98: 99, 00, 01 with a one-cycle done pulse at 00.
  - down from 01: 00, 99, with a done pulse at 99; running stays 1.
- rst asserted mid-RUN with start also high:
  - next cycle all outputs are reset values; state IDLE.
